// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - synchronize, debounce and one-shot the left/right/drop buttons
// Left/right add press-and-hold auto-repeat and mutual suppression while both are held.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 40000000,
    parameter int REPEAT_RATE     = 15000000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_l_raw,
    input  logic btn_r_raw,
    input  logic btn_drop_raw,
    output logic btn_l,
    output logic btn_r,
    output logic btn_drop,
    output logic l_stable,
    output logic r_stable,
    output logic drop_stable
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, FIRE, DELAY, REPEAT} rstate_t;

    // Channel index: 0 = left, 1 = right, 2 = drop.
    logic [2:0]            raw;
    logic [2:0]            s1_q, s2_q;
    logic [2:0]            stable_q, stable_d;
    logic [2:0][CNT_W-1:0] dcnt_q, dcnt_d;
    logic                  drop_prev_q;
    logic                  drop_q;
    logic [1:0]            lr_q;
    logic [1:0][CNT_W-1:0] rcnt_q;
    rstate_t [1:0]         st_q;
    logic                  conflict_q, conflict_d;

    assign raw = {btn_drop_raw, btn_r_raw, btn_l_raw};

    always_comb begin
        stable_d = stable_q;
        dcnt_d   = '0;
        for (int i = 0; i < 3; i++) begin
            if (s2_q[i] != stable_q[i]) begin
                if (dcnt_q[i] == DB_LAST) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + ONE;
                end
            end
        end
    end

    // conflict_d gates pulses on the edge where both levels become high, so no
    // pulse is ever visible during a cycle with both left and right held.
    assign conflict_q = stable_q[0] & stable_q[1];
    assign conflict_d = stable_d[0] & stable_d[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            stable_q    <= '0;
            dcnt_q      <= '0;
            drop_prev_q <= 1'b0;
            drop_q      <= 1'b0;
            lr_q        <= '0;
            rcnt_q      <= '0;
            st_q        <= {IDLE, IDLE};
        end else begin
            s1_q        <= raw;
            s2_q        <= s1_q;
            stable_q    <= stable_d;
            dcnt_q      <= dcnt_d;
            drop_prev_q <= stable_q[2];
            drop_q      <= stable_q[2] & ~drop_prev_q;
            for (int i = 0; i < 2; i++) begin
                lr_q[i] <= 1'b0;
                case (st_q[i])
                    IDLE: begin
                        rcnt_q[i] <= '0;
                        if (stable_q[i]) begin
                            if (conflict_q) begin
                                st_q[i] <= DELAY;
                            end else begin
                                st_q[i] <= FIRE;
                                lr_q[i] <= ~conflict_d;
                            end
                        end
                    end
                    FIRE: begin
                        rcnt_q[i] <= '0;
                        st_q[i]   <= DELAY;
                    end
                    DELAY, REPEAT: begin
                        if (!stable_q[i]) begin
                            st_q[i]   <= IDLE;
                            rcnt_q[i] <= '0;
                        end else if (conflict_q) begin
                            rcnt_q[i] <= '0;
                        end else if (rcnt_q[i] == ((st_q[i] == DELAY) ? RD_LAST : RR_LAST)) begin
                            st_q[i]   <= REPEAT;
                            rcnt_q[i] <= '0;
                            lr_q[i]   <= ~conflict_d;
                        end else begin
                            rcnt_q[i] <= rcnt_q[i] + ONE;
                        end
                    end
                    default: begin
                        st_q[i]   <= IDLE;
                        rcnt_q[i] <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_l       = lr_q[0];
    assign btn_r       = lr_q[1];
    assign btn_drop    = drop_q;
    assign l_stable    = stable_q[0];
    assign r_stable    = stable_q[1];
    assign drop_stable = stable_q[2];

endmodule
